// File: rtl/msi001_spi_rx.sv
// msi001_spi_rx: receive side of the MSI001 tuner 3-wire SPI write path.
// Samples data/clk/en with the system clock, reassembles MSB-first frames,
// checks the bit count, and mirrors valid frames into a shadow register file.
module msi001_spi_rx #(
  parameter int unsigned FRAME_BITS  = 24,
  parameter int unsigned ADDR_BITS   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spi_msi001_data_in,
  input  logic                            spi_msi001_clk_in,
  input  logic                            spi_msi001_en_in,
  output logic [FRAME_BITS-1:0]           rx_data,
  output logic                            rx_valid,
  output logic                            rx_err,
  output logic                            busy,
  input  logic [ADDR_BITS-1:0]            rd_addr,
  output logic [FRAME_BITS-ADDR_BITS-1:0] rd_data
);

  // Fewer than two synchronizer stages is not metastability-safe; clamp.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned PAY_W  = FRAME_BITS - ADDR_BITS;
  localparam int unsigned N_REG  = 1 << ADDR_BITS;
  localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Synchronizer chains plus one delay stage per serial input
  logic [SYNC_N-1:0] data_sync_q, data_sync_d;
  logic [SYNC_N-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_N-1:0] en_sync_q,   en_sync_d;
  logic              data_del_q,  data_del_d;
  logic              sclk_del_q,  sclk_del_d;
  logic              en_del_q,    en_del_d;

  // Edge events derived from synchronized levels only
  logic sclk_rise;
  logic en_fall;
  logic en_rise;

  // Frame assembly state
  logic [0:0]            state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [FRAME_BITS-1:0] shift_q,    shift_d;
  logic [FRAME_BITS-1:0] rx_data_q,  rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_err_q,   rx_err_d;
  logic                  busy_q,     busy_d;
  logic                  wr_en;

  // Shadow register file and its registered read port
  logic [PAY_W-1:0] regs_q [N_REG];
  logic [PAY_W-1:0] regs_d [N_REG];
  logic [PAY_W-1:0] rd_data_q, rd_data_d;

  // Next value of the synchronizer chains and delay stages
  always_comb begin
    data_sync_d = {data_sync_q[SYNC_N-2:0], spi_msi001_data_in};
    sclk_sync_d = {sclk_sync_q[SYNC_N-2:0], spi_msi001_clk_in};
    en_sync_d   = {en_sync_q[SYNC_N-2:0],   spi_msi001_en_in};
    data_del_d  = data_sync_q[SYNC_N-1];
    sclk_del_d  = sclk_sync_q[SYNC_N-1];
    en_del_d    = en_sync_q[SYNC_N-1];
  end

  // Edge detect: synchronized level against its one-cycle-older copy
  always_comb begin
    sclk_rise = sclk_sync_q[SYNC_N-1] & ~sclk_del_q;
    en_fall   = ~en_sync_q[SYNC_N-1] & en_del_q;
    en_rise   = en_sync_q[SYNC_N-1] & ~en_del_q;
  end

  // Synchronizer registers; en resets low so a bus held low after reset
  // produces no falling edge and is not mistaken for a new frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_sync_q <= '0;
      sclk_sync_q <= '0;
      en_sync_q   <= '0;
      data_del_q  <= 1'b0;
      sclk_del_q  <= 1'b0;
      en_del_q    <= 1'b0;
    end else begin
      data_sync_q <= data_sync_d;
      sclk_sync_q <= sclk_sync_d;
      en_sync_q   <= en_sync_d;
      data_del_q  <= data_del_d;
      sclk_del_q  <= sclk_del_d;
      en_del_q    <= en_del_d;
    end
  end

  // Frame FSM: open on en fall, shift on sclk rise, close and judge on en rise
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // sclk edges here, including one coincident with en fall, are dropped
        if (en_fall) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // en rise takes priority so a coincident sclk edge is not counted
        if (en_rise) begin
          if (cnt_q == CNT_FULL) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            wr_en      = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], data_del_q};
          // saturate one past a full frame so overlong frames stay flagged
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  // Register file write and read-port next values
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[shift_q[ADDR_BITS-1:0]] = shift_q[FRAME_BITS-1:ADDR_BITS];
    end
    // read sees the pre-write value when addresses collide
    rd_data_d = regs_q[rd_addr];
  end

  // FSM, frame datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      busy_q     <= busy_d;
    end
  end

  // Register file storage and registered read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_REG); i++) begin
        regs_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/msi001_spi_rx.md
# msi001_spi_rx

Receive-side counterpart of the MSI001 tuner SPI write path. The block samples the 3-wire serial bus (data, clock, enable) with the system clock. It reassembles 24-bit MSB-first frames and validates the bit count. Valid frames are written into a shadow register file indexed by the frame's 4-bit address field. It sits on the tuner control bus as an on-chip monitor/loopback, so firmware and benches can read back what was actually sent to the tuner.

## Interface
Parameters:
- FRAME_BITS, 24, bits per valid frame
- ADDR_BITS, 4, address field width, taken from the frame LSBs
- SYNC_STAGES, 2, flip-flop stages on each serial input, minimum 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous assert, active-low
- spi_msi001_data_in  in  1  serial data, MSB first
- spi_msi001_clk_in  in  1  serial clock; data sampled on its rising edge
- spi_msi001_en_in  in  1  frame enable, active-low; low for the whole frame
- rx_data  out  FRAME_BITS  last valid frame word
- rx_valid  out  1  one-cycle pulse: rx_data updated, register file written
- rx_err  out  1  one-cycle pulse: frame closed with bit count != FRAME_BITS
- busy  out  1  high while a frame is open (state SHIFT)
- rd_addr  in  ADDR_BITS  register file read address
- rd_data  out  FRAME_BITS-ADDR_BITS  register file read data, registered

## Operation
- Each serial input passes through a SYNC_STAGES synchronizer, then one more register for edge detection. All decisions use the synchronized signals only.
- FSM, two states:
  - IDLE: on a synchronized en falling edge, clear the bit counter and shift register, then go to SHIFT.
  - SHIFT: on each synchronized clk rising edge, shift data into the LSB and increment the counter. The counter saturates at FRAME_BITS+1.
  - SHIFT, on a synchronized en rising edge:
    - count == FRAME_BITS: load rx_data with the shift register, pulse rx_valid, write shift[FRAME_BITS-1:ADDR_BITS] into reg[shift[ADDR_BITS-1:0]].
    - Otherwise: pulse rx_err, no write, rx_data unchanged.
    - In both cases, return to IDLE.
- Register file: 2^ADDR_BITS entries of FRAME_BITS-ADDR_BITS bits. Every entry resets to 0.
- Read port: rd_data = reg[rd_addr], registered, 1-cycle latency.
  - Read and write to the same address in the same cycle returns the old value.
  - The new value is visible the next cycle.
- Serial clock edges in IDLE are ignored.
- A serial clock rising edge detected in the same cycle as the en falling edge is ignored; it does not count as bit 1.
- A serial clock rising edge detected in the same cycle as the en rising edge is ignored; the frame closes with the current count.
- An en falling edge while in SHIFT cannot occur, since en is already low. Glitches shorter than one synchronized sample are not filtered.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_err=0, busy=0, rd_data=0, all register entries=0, FSM=IDLE, counter=0.
- Reset asserted mid-frame: the partial frame is discarded with no pulse and no write. After release, the block waits for a fresh en falling edge; a bus still held low is not treated as a frame.
- Input-to-detection latency: SYNC_STAGES+1 clk edges from the first clk edge that samples the new pin level.
- rx_valid / rx_err: high for exactly one cycle, on edge SYNC_STAGES+2 after en is first sampled high at the pin.
- rx_data and the register write take effect in the same cycle rx_valid is high.
- busy rises one cycle after the en falling edge is detected and falls in the same cycle as the rx_valid/rx_err pulse.
- Bus requirements:
  - Serial clock high and low phases, and en setup/hold around the serial clock, each ≥ SYNC_STAGES+1 clk periods.
  - Data stable ≥ 2 clk periods around each serial clock rising edge.
- Back-to-back frames: en high for ≥ SYNC_STAGES+2 clk periods between frames. Throughput is one frame per en low/high pair.

## Test plan
- Reset, then idle bus → all outputs 0, rd_data=0 for every rd_addr 0..15.
- Frame 24'hEBAEAB (8 clk periods per serial bit) → one rx_valid pulse, rx_data=24'hEBAEAB, rx_err=0. Next, rd_addr=4'hB returns 20'hEBAEA on the following cycle.
- Frames with 23 and with 25 serial clock pulses → one rx_err pulse each, no rx_valid, rx_data and all register entries unchanged. The 25-pulse case also proves counter saturation.
- Two back-to-back frames 24'h09AFAB then 24'h0000FB with minimum en-high gap → rx_valid twice. Afterwards reg[0xB]=20'h09AFA and reg[0xB] is then overwritten by 24'h0000FB's payload 20'h0000F. Check the intermediate read after the first frame.
- rst asserted after 12 bits of 24'h123456, released while en is still low, then en raised → no rx_valid, no rx_err, busy=0, register file all zero.
- Serial clock toggling with en high, plus a serial clock edge coincident with the en edges → no pulses, bit count unaffected. A following clean 24-bit frame is accepted.
